// File: rtl/sqrt_pipe_collector_if.sv
// Handshake bundle for the sqrt pipe collector: operand input, pipe drive/return, result output.
interface sqrt_pipe_collector_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned RW = (WIDTH + 1) / 2;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic             pipe_en;
  logic [WIDTH-1:0] pipe_a;
  logic [RW-1:0]    pipe_root;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_root;
  logic             out_exact;

  modport master (
    output in_valid, in_a, pipe_root, out_ready,
    input  in_ready, pipe_en, pipe_a, out_valid, out_root, out_exact
  );

  modport slave (
    input  in_valid, in_a, pipe_root, out_ready,
    output in_ready, pipe_en, pipe_a, out_valid, out_root, out_exact
  );
endinterface

// File: rtl/sqrt_pipe_collector.sv
// Flow-control shell around a stall-mode DW_sqrt_pipe: token tracking of the pipe latency,
// credit-based input acceptance and an output FIFO of {root, exact} results.
module sqrt_pipe_collector #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned DEPTH      = 4
) (
  input logic                  clk,
  input logic                  rst,
  sqrt_pipe_collector_if.slave bus
);
  localparam int unsigned RW  = (WIDTH + 1) / 2;
  localparam int unsigned PRW = 2 * RW;
  localparam int unsigned EW  = RW + 1;
  localparam int unsigned L   = NUM_STAGES - 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SW  = $clog2(DEPTH + NUM_STAGES + 1);

  logic             in_fire;
  logic             push;
  logic             pop;
  logic             push_exact;
  logic [WIDTH-1:0] push_opnd;
  logic [SW-1:0]    inflight;
  logic [PRW-1:0]   root_sq;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign in_fire    = bus.in_valid & bus.in_ready;
  assign bus.pipe_a = bus.in_a;

  generate
    if (L == 0) begin : g_comb
      // Combinational pipe: the root belongs to the operand presented this cycle.
      assign bus.pipe_en = in_fire;
      assign push        = in_fire;
      assign push_opnd   = bus.in_a;
      assign inflight    = '0;
    end else begin : g_tok
      localparam logic [L-1:0] LOW_MASK = L'((64'd1 << (L - 1)) - 64'd1);

      logic [L-1:0]     tok;
      logic [WIDTH-1:0] opnd [L];

      // Keep the pipe moving while any token has not yet reached the last stage.
      assign bus.pipe_en = in_fire | (|(tok & LOW_MASK));
      assign push        = tok[L-1];
      assign push_opnd   = opnd[L-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          tok <= '0;
          for (int i = 0; i < int'(L); i++) opnd[i] <= '0;
        end else if (bus.pipe_en) begin
          tok[0]  <= in_fire;
          opnd[0] <= bus.in_a;
          for (int i = 1; i < int'(L); i++) begin
            tok[i]  <= tok[i-1];
            opnd[i] <= opnd[i-1];
          end
        end else begin
          tok[L-1] <= 1'b0;
        end
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(L); i++) inflight = inflight + SW'(tok[i]);
      end
    end
  endgenerate

  assign root_sq    = {RW'(0), bus.pipe_root} * {RW'(0), bus.pipe_root};
  assign push_exact = (root_sq == PRW'(push_opnd));

  // Tokens in flight reserve FIFO slots, so a push always finds room.
  assign bus.in_ready  = (SW'(count) + inflight) < SW'(DEPTH);
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_root  = mem[rd_ptr][EW-1:1];
  assign bus.out_exact = mem[rd_ptr][0];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.pipe_root, push_exact};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_sqrt_pipe_collector.sv
// Scoreboard bench for sqrt_pipe_collector with behavioural stall-mode pipes for NUM_STAGES 2, 4 and 1.
module tb_sqrt_pipe_collector;
  typedef struct {
    logic [3:0] root;
    logic       exact;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic       v   [3];
  logic [7:0] ad  [3];
  logic       r   [3];
  logic       rdy [3];
  int         acc [3];
  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_pipe_collector_if #(.WIDTH(8)) b0 ();
  sqrt_pipe_collector_if #(.WIDTH(8)) b1 ();
  sqrt_pipe_collector_if #(.WIDTH(8)) b2 ();

  sqrt_pipe_collector #(.WIDTH(8), .NUM_STAGES(2), .DEPTH(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  sqrt_pipe_collector #(.WIDTH(8), .NUM_STAGES(4), .DEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  sqrt_pipe_collector #(.WIDTH(8), .NUM_STAGES(1), .DEPTH(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.in_valid = v[0]; assign b0.in_a = ad[0]; assign b0.out_ready = r[0]; assign rdy[0] = b0.in_ready;
  assign b1.in_valid = v[1]; assign b1.in_a = ad[1]; assign b1.out_ready = r[1]; assign rdy[1] = b1.in_ready;
  assign b2.in_valid = v[2]; assign b2.in_a = ad[2]; assign b2.out_ready = r[2]; assign rdy[2] = b2.in_ready;

  function automatic logic [3:0] isqrt(input logic [7:0] a);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 0; i < 16; i++) if (i * i <= int'(a)) res = 4'(i);
    return res;
  endfunction

  // Stall-mode pipe stand-ins: stages advance only on en.
  logic [3:0] p0;
  logic [3:0] p1 [3];
  always @(posedge clk) if (b0.pipe_en) p0 <= isqrt(b0.pipe_a);
  always @(posedge clk) if (b1.pipe_en) begin
    p1[0] <= isqrt(b1.pipe_a);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign b0.pipe_root = p0;
  assign b1.pipe_root = p1[2];
  assign b2.pipe_root = isqrt(b2.pipe_a);

  function automatic int ns_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_exp(input int d, input logic [3:0] root, input logic ex, input int due);
    exp_t e;
    e.root = root; e.exact = ex; e.due = due;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int d, input logic [3:0] root, input logic ex);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      total++; bad++;
      $display("FAIL pop_unexpected dut%0d got root=%0d want no output (cycle %0d)", d, root, cyc);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("root_dut%0d", d), int'(root), int'(e.root));
      chk($sformatf("exact_dut%0d", d), int'(ex), int'(e.exact));
      if (e.due >= 0) chk($sformatf("latency_dut%0d", d), cyc, e.due);
    end
  endtask

  always @(negedge clk) if (!rst && b0.out_valid === 1'b1 && b0.out_ready === 1'b1) pop_check(0, b0.out_root, b0.out_exact);
  always @(negedge clk) if (!rst && b1.out_valid === 1'b1 && b1.out_ready === 1'b1) pop_check(1, b1.out_root, b1.out_exact);
  always @(negedge clk) if (!rst && b2.out_valid === 1'b1 && b2.out_ready === 1'b1) pop_check(2, b2.out_root, b2.out_exact);

  // mode: 0 = no result expected, 1 = expect result, 2 = expect result at exact latency
  task automatic send(input int d, input logic [7:0] a, input logic [3:0] root, input logic ex, input int mode);
    int n;
    bit done;
    n = 0; done = 0;
    v[d] = 1'b1; ad[d] = a;
    while (!done) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        acc[d]++;
        if (mode != 0) push_exp(d, root, ex, (mode == 2) ? cyc + ns_of(d) : -1);
        done = 1;
      end else if (n >= 60) begin
        total++; bad++;
        $display("FAIL send_timeout dut%0d got in_ready=0 want in_ready=1 within 60 cycles", d);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
    end
    v[d] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; ad[i] = 8'd0; r[i] = 1'b1; acc[i] = 0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ready_ns2", int'(b0.in_ready), 1);
    chk("reset_en_ns2",    int'(b0.pipe_en), 0);
    chk("reset_valid_ns2", int'(b0.out_valid), 0);
    chk("reset_ready_ns4", int'(b1.in_ready), 1);
    chk("reset_en_ns4",    int'(b1.pipe_en), 0);
    chk("reset_valid_ns4", int'(b1.out_valid), 0);
    chk("reset_ready_ns1", int'(b2.in_ready), 1);
    chk("reset_en_ns1",    int'(b2.pipe_en), 0);
    chk("reset_valid_ns1", int'(b2.out_valid), 0);
    @(posedge clk); #1;

    // back-to-back operands with exact latency
    send(0, 8'd0,   4'd0,  1'b1, 2);
    send(0, 8'd1,   4'd1,  1'b1, 2);
    send(0, 8'd2,   4'd1,  1'b0, 2);
    send(0, 8'd255, 4'd15, 1'b0, 2);
    send(0, 8'd144, 4'd12, 1'b1, 2);
    send(0, 8'd143, 4'd11, 1'b0, 2);
    wait_drain();

    // backpressure: only DEPTH operands accepted until the consumer drains
    r[0] = 1'b0;
    acc[0] = 0;
    fork
      begin
        send(0, 8'd16,  4'd4,  1'b1, 1);
        send(0, 8'd17,  4'd4,  1'b0, 1);
        send(0, 8'd25,  4'd5,  1'b1, 1);
        send(0, 8'd26,  4'd5,  1'b0, 1);
        send(0, 8'd36,  4'd6,  1'b1, 1);
        send(0, 8'd200, 4'd14, 1'b0, 1);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", int'(b0.in_ready), 0);
        chk("bp_pipe_en",  int'(b0.pipe_en), 0);
        chk("bp_accepted", acc[0], 4);
        chk("bp_out_valid", int'(b0.out_valid), 1);
        @(posedge clk); #1;
        r[0] = 1'b1;
      end
    join
    wait_drain();

    // push and pop in the same cycle with three held and one in flight
    r[0] = 1'b0;
    send(0, 8'd49, 4'd7, 1'b1, 1);
    send(0, 8'd50, 4'd7, 1'b0, 1);
    send(0, 8'd64, 4'd8, 1'b1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("three_held_ready", int'(b0.in_ready), 1);
    @(posedge clk); #1;
    send(0, 8'd100, 4'd10, 1'b1, 1);
    r[0] = 1'b1;
    @(negedge clk);
    chk("pop_not_credited", int'(b0.in_ready), 0);
    @(posedge clk); #1;
    r[0] = 1'b0;
    @(negedge clk);
    chk("pushpop_ready", int'(b0.in_ready), 1);
    chk("pushpop_valid", int'(b0.out_valid), 1);
    @(posedge clk); #1;
    send(0, 8'd121, 4'd11, 1'b1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("refill_full_ready", int'(b0.in_ready), 0);
    @(posedge clk); #1;
    r[0] = 1'b1;
    wait_drain();

    // reset with three tokens in flight in the four-stage pipe
    send(1, 8'd1, 4'd1, 1'b1, 0);
    send(1, 8'd4, 4'd2, 1'b1, 0);
    send(1, 8'd9, 4'd3, 1'b1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(b1.in_ready), 1);
    chk("midrst_en",    int'(b1.pipe_en), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("midrst_no_stale_%0d", i), int'(b1.out_valid), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(1, 8'd225, 4'd15, 1'b1, 2);
    wait_drain();

    // combinational pipe
    send(2, 8'd81, 4'd9, 1'b1, 2);
    send(2, 8'd80, 4'd8, 1'b0, 2);
    wait_drain();

    repeat (3) @(posedge clk);
    chk("queues_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
